// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
//   DEFAULT_WIDTH / DEFAULT_N : default data width and channel count
//   sel_width(n)              : width of a channel index, clog2 with a floor of 1
package rr_mux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_N     = 4;

  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = int'($clog2(n));
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search.
//   in_valid : per-channel request vector
//   ptr      : index where the search starts (always < N)
//   gnt_vld  : some channel at or after ptr (with wrap) is valid
//   gnt_idx  : first valid channel found, '0 when gnt_vld=0
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    logic [SEL_W-1:0] idx_s;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_s   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr < N, so one subtraction is enough to wrap.
      idx = 32'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_s = SEL_W'(idx);
      if (!gnt_vld && in_valid[idx_s]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_s;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel WIDTH-bit stream multiplexer with round-robin arbitration and a
// registered output stage.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_data/in_valid       : producer streams, channel i at [i*WIDTH +: WIDTH]
//   in_ready               : one-hot (or zero) accept strobe per channel
//   out_data/out_valid     : registered selected word
//   out_ready              : consumer accept
//   out_sel                : channel that supplied out_data
//   force_en/force_sel     : only when RR_MUX_FIXED_SEL_EN is defined; pins the
//                            grant to force_sel and freezes the rotation pointer
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
`ifdef RR_MUX_FIXED_SEL_EN
  ,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel
`endif
);

  logic [WIDTH-1:0] ch_data [N];
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic             arb_vld;
  logic [SEL_W-1:0] arb_idx;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             advance;
  logic             load;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .in_valid (in_valid),
    .ptr      (ptr_q),
    .gnt_vld  (arb_vld),
    .gnt_idx  (arb_idx)
  );

  always_comb begin
    gnt_vld = arb_vld;
    gnt_idx = arb_idx;
    advance = 1'b1;
`ifdef RR_MUX_FIXED_SEL_EN
    if (force_en) begin
      // Out-of-range force_sel selects nothing.
      gnt_vld = (32'(force_sel) < N) && in_valid[force_sel];
      gnt_idx = force_sel;
      advance = 1'b0;
    end
`endif
  end

  // The register can take a word when it is empty or being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Gated by rst_n so nothing looks accepted while reset is held.
  assign in_ready = (rst_n && load && gnt_vld) ? (N'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (gnt_vld) begin
        out_data_d  = ch_data[gnt_idx];
        out_sel_d   = gnt_idx;
        out_valid_d = 1'b1;
        if (advance) begin
          ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: an N=4 and an N=3 instance driven side by
// side, compared every cycle against a queue-free behavioural model.
module tb_rr_mux_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [3:0]  out_data4;
  logic        out_valid4, out_ready4;
  logic [1:0]  out_sel4;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [3:0]  out_data3;
  logic        out_valid3, out_ready3;
  logic [1:0]  out_sel3;

  logic        force_en;
  logic [1:0]  force_sel4, force_sel3;

  int nchk = 0;
  int nbad = 0;

  // Model state: index 0 is the N=4 instance, index 1 the N=3 instance.
  int m_ptr[2];
  int m_ov[2];
  int m_od[2];
  int m_os[2];

  rr_mux_arb #(.WIDTH(4), .N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_sel   (out_sel4)
`ifdef RR_MUX_FIXED_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel4)
`endif
  );

  rr_mux_arb #(.WIDTH(4), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_sel   (out_sel3)
`ifdef RR_MUX_FIXED_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel3)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      m_ov[k]  = 0;
      m_od[k]  = 0;
      m_os[k]  = 0;
    end
  endtask

  // Grant = the valid channel at the smallest forward distance from ptr.
  function automatic int pick(input int n, input int valid, input int ptr);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = n;
    for (int i = 0; i < n; i++) begin
      if (((valid >> i) & 1) == 1) begin
        d = (i - ptr + n) % n;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model(input int k, input int n, input string nm, input int data,
                       input int valid, input int oready, input int fen, input int fsel,
                       input int got_ov, input int got_od, input int got_os,
                       input int got_rdy);
    int load;
    int g;
    int exp_rdy;
    check({nm, "_out_valid"}, got_ov, m_ov[k]);
    check({nm, "_out_data"}, got_od, m_od[k]);
    check({nm, "_out_sel"}, got_os, m_os[k]);
    load = (m_ov[k] == 0 || oready != 0) ? 1 : 0;
    if (fen != 0) begin
      g = (fsel < n && ((valid >> fsel) & 1) == 1) ? fsel : -1;
    end else begin
      g = pick(n, valid, m_ptr[k]);
    end
    exp_rdy = (rst_n && load == 1 && g >= 0) ? (1 << g) : 0;
    check({nm, "_in_ready"}, got_rdy, exp_rdy);
    if (!rst_n) begin
      m_ptr[k] = 0;
      m_ov[k]  = 0;
      m_od[k]  = 0;
      m_os[k]  = 0;
    end else if (load == 1) begin
      if (g >= 0) begin
        m_od[k] = (data >> (4 * g)) & 15;
        m_os[k] = g;
        m_ov[k] = 1;
        if (fen == 0) m_ptr[k] = (g + 1) % n;
      end else begin
        m_ov[k] = 0;
      end
    end
  endtask

  // Inputs are changed just after a rising edge; everything is checked at the
  // falling edge, then the model advances to match the coming rising edge.
  task automatic step();
    @(negedge clk);
    model(0, 4, "n4", int'(in_data4), int'(in_valid4), int'(out_ready4), int'(force_en),
          int'(force_sel4), int'(out_valid4), int'(out_data4), int'(out_sel4),
          int'(in_ready4));
    model(1, 3, "n3", int'(in_data3), int'(in_valid3), int'(out_ready3), int'(force_en),
          int'(force_sel3), int'(out_valid3), int'(out_data3), int'(out_sel3),
          int'(in_ready3));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_word;
    rr_word    = 'hDCBA;
    force_en   = 1'b0;
    force_sel4 = '0;
    force_sel3 = '0;
    in_valid4  = '1;
    in_valid3  = '1;
    in_data4   = 16'h1234;
    in_data3   = 12'h567;
    out_ready4 = 1'b1;
    out_ready3 = 1'b1;
    model_reset();

    // Reset held with every channel requesting.
    repeat (2) step();

    // Release between edges: nothing may appear before the next rising edge.
    rst_n = 1'b1;
    #1;
    check("rel_out_valid4", int'(out_valid4), 0);
    check("rel_out_data4", int'(out_data4), 0);
    check("rel_out_valid3", int'(out_valid3), 0);

    // Round-robin over D,C,B,A; the N=3 instance sees only ch1 so its ptr ends at 2.
    in_data4  = 16'hDCBA;
    in_valid3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_sel", int'(out_sel4), i % 4);
      check("rr_data", int'(out_data4), (rr_word >> (4 * (i % 4))) & 15);
    end

    // N=3, all valid, starting from ptr=2.
    in_valid3 = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("n3_sel", int'(out_sel3), (i + 2) % 3);
    end

    // Backpressure: word held, nothing accepted.
    out_ready4 = 1'b0;
    repeat (3) begin
      step();
      check("bp_in_ready", int'(in_ready4), 0);
      check("bp_hold_valid", int'(out_valid4), 1);
    end
    out_ready4 = 1'b1;
    step();

    // Sparse: ch2 alone, then ch1/ch3 with ptr=3.
    in_valid4 = 4'b0100;
    repeat (3) begin
      step();
      check("sparse_sel", int'(out_sel4), 2);
    end
    in_valid4 = 4'b1010;
    step();
    check("wrap_sel_a", int'(out_sel4), 3);
    step();
    check("wrap_sel_b", int'(out_sel4), 1);

    // Idle: output empties, ptr holds at 2.
    in_valid4 = '0;
    in_valid3 = '0;
    step();
    check("idle_valid", int'(out_valid4), 0);
    step();
    in_valid4 = '1;
    in_valid3 = '1;
    step();
    check("idle_ptr_sel", int'(out_sel4), 2);

`ifdef RR_MUX_FIXED_SEL_EN
    force_en   = 1'b1;
    force_sel4 = 2'd1;
    force_sel3 = 2'd3;
    repeat (3) begin
      step();
      check("force_sel", int'(out_sel4), 1);
      check("force_oor_valid", int'(out_valid3), 0);
    end
    force_en = 1'b0;
    step();
    check("force_resume_sel", int'(out_sel4), 3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid4  = 4'($urandom);
      in_data4   = 16'($urandom);
      out_ready4 = (($urandom % 4) != 0);
      in_valid3  = 3'($urandom);
      in_data3   = 12'($urandom);
      out_ready3 = (($urandom % 4) != 0);
`ifdef RR_MUX_FIXED_SEL_EN
      force_en   = (($urandom % 8) == 0);
      force_sel4 = 2'($urandom);
      force_sel3 = 2'($urandom);
`endif
      step();
    end

    // Reset mid-operation drops the held word immediately.
    force_en   = 1'b0;
    in_valid4  = '1;
    in_valid3  = '1;
    out_ready4 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid4", int'(out_valid4), 0);
    check("midrst_valid3", int'(out_valid3), 0);
    check("midrst_ready4", int'(in_ready4), 0);
    model_reset();
    step();
    rst_n      = 1'b1;
    out_ready4 = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
